axis_rr_pkt_arbiter: RTL
========================

// Module: axis_rr_pkt_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter sharing one AXI4-Stream output among S_COUNT inputs.
//  A grant is held from the first beat of a packet until its tlast beat, so packets never interleave.
//  Muxed beats pass through a 2-entry skid output register: full throughput, registered m_axis.
//  Sits ahead of shared MAC TX / FIFO resources that accept one stream at a time.
// PARAMETERS
//  S_COUNT      4             number of input streams (2..16)
//  DATA_WIDTH   8             tdata width, bits
//  KEEP_ENABLE  DATA_WIDTH>8  propagate tkeep; when 0, m_axis_tkeep is driven all-ones
//  KEEP_WIDTH   DATA_WIDTH/8  tkeep width
//  USER_ENABLE  1             propagate tuser; when 0, m_axis_tuser is driven 0
//  USER_WIDTH   1             tuser width
//  CL_S_COUNT   $clog2(S_COUNT)  width of the grant index (localparam)
// PORTS
//  clk            in   1                    clock, all logic on posedge
//  rst            in   1                    synchronous, active-high reset
//  s_axis_tdata   in   S_COUNT*DATA_WIDTH   input data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_axis_tkeep   in   S_COUNT*KEEP_WIDTH   input byte enables
//  s_axis_tvalid  in   S_COUNT              per-port valid
//  s_axis_tready  out  S_COUNT              per-port ready
//  s_axis_tlast   in   S_COUNT              per-port end of packet
//  s_axis_tuser   in   S_COUNT*USER_WIDTH   per-port user sideband
//  m_axis_tdata   out  DATA_WIDTH           output data
//  m_axis_tkeep   out  KEEP_WIDTH           output byte enables
//  m_axis_tvalid  out  1                    output valid
//  m_axis_tready  in   1                    output ready
//  m_axis_tlast   out  1                    output end of packet
//  m_axis_tid     out  CL_S_COUNT           index of the source port of the current beat
//  m_axis_tuser   out  USER_WIDTH           output user sideband
//  grant_valid    out  1                    a packet grant is currently held
//  grant_index    out  CL_S_COUNT           index of the port holding the grant
// BEHAVIOUR
//  States: IDLE (no grant), GRANT (packet in flight). Grant regs: grant_valid_reg, grant_index_reg.
//  IDLE: if any s_axis_tvalid, register the round-robin winner: first requesting port at or after
//    rr_ptr, wrapping S_COUNT-1 -> 0. Go to GRANT next cycle. No s_axis_tready asserts in IDLE.
//  GRANT: s_axis_tready[grant_index] = !out_full (skid not full); all other tready bits 0.
//  Accepted beat = tvalid & tready on the granted port. It enters the output register; m_axis_tvalid
//    rises the next cycle (1-cycle latency). m_axis_tid = grant_index at acceptance.
//  Accepted beat with tlast: go to IDLE; rr_ptr <= grant_index+1 (mod S_COUNT).
//    Re-arbitration occurs in the next cycle: one idle input cycle per packet.
//  Mid-packet tvalid deassertion on the granted port: grant is held; no other port is served.
//  Skid: 2 entries. out_full sets when the output holds a beat, m_axis_tready=0, and a new beat
//    is accepted in the same cycle. Full throughput when m_axis_tready stays high.
//  Reset: state IDLE, rr_ptr 0, grant_valid 0, grant_index 0, skid empty, m_axis_tvalid 0,
//    s_axis_tready all 0. Reset mid-packet drops the partial packet; no recovery tlast is emitted.
//  Input requests during reset are ignored; after reset port 0 has highest priority.
// CONFIGURATION
//  `define AXIS_ARB_STATS_EN adds outputs stat_pkt_count [S_COUNT*16] and input stat_clear.
//    stat_pkt_count: per-port 16-bit count of tlast beats accepted, wraps 16'hFFFF -> 0.
//    stat_clear: synchronous, takes precedence over an increment in the same cycle.
//    Counters reset to 0.
//  Macro undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package axis_arb_pkg: state encoding localparams (ST_IDLE, ST_GRANT), STAT_WIDTH=16,
//    function clog2.
//  Sub-module axis_rr_arbiter_core, combinational: request vector and rr_ptr in,
//    winner index and winner-valid out.
//  Top level holds the FSM, the grant registers, the data mux and the skid output register.
// TESTING
//  1 Port 2 sends a 3-beat packet 0xA1,0xA2,0xA3 (tlast on beat 3), m_axis_tready=1:
//    beats appear on consecutive cycles, m_axis_tid=2, tlast on 0xA3.
//  2 All 4 ports request 2-beat packets simultaneously after reset:
//    output packet order is ports 0,1,2,3, and no beats interleave.
//  3 Port 1 stalls tvalid 5 cycles mid-packet while port 3 requests:
//    port 3 stays ungranted until port 1's tlast beat is accepted.
//  4 m_axis_tready toggles 1,0,0,1 during a 4-beat burst:
//    no beat is lost or duplicated, skid full blocks s_axis_tready, and order is preserved.
//  5 rst asserted mid-packet on port 0: next cycle m_axis_tvalid=0, grant_valid=0;
//    a new port-1 packet then passes intact.
//  6 With AXIS_ARB_STATS_EN defined, 3 packets from port 0 then stat_clear:
//    stat_pkt_count[15:0] reads 3, then 0.

Source files
------------

// File: rtl/axis_rr_pkt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_arb_pkg
// Brief    : Shared state encoding, statistics width and clog2 helper for
//            the packet round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int STAT_WIDTH = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_rr_pkt_arbiter_core.sv
`default_nettype none
// ============================================================================
// Module   : axis_rr_arbiter_core
// Brief    : Combinational round-robin pick: first requester at or after
//            rr_ptr, wrapping from the top index back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter_core
  import axis_arb_pkg::*;
#(
  parameter  int S_COUNT    = 4,
  localparam int CL_S_COUNT = clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0]    request,
  input  logic [CL_S_COUNT-1:0] rr_ptr,
  output logic [CL_S_COUNT-1:0] winner_index,
  output logic                  winner_valid
);

  int                    w_pos;
  logic [CL_S_COUNT-1:0] w_idx;

  // Scan from farthest to nearest offset so the nearest requester wins last.
  always_comb begin
    winner_index = '0;
    winner_valid = 1'b0;
    w_pos        = 0;
    w_idx        = '0;
    for (int k = S_COUNT - 1; k >= 0; k--) begin
      w_pos = int'(rr_ptr) + k;
      if (w_pos >= S_COUNT) w_pos = w_pos - S_COUNT;
      w_idx = CL_S_COUNT'(w_pos);
      if (request[w_idx]) begin
        winner_index = w_idx;
        winner_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_rr_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_rr_pkt_arbiter
// Brief    : Packet-aware round-robin AXI4-Stream arbiter with a 2-entry skid
//            output register. Optional per-port packet counters are built
//            when AXIS_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module axis_rr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int S_COUNT     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter  int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter  int USER_ENABLE = 1,
  parameter  int USER_WIDTH  = 1,
  localparam int CL_S_COUNT  = clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [CL_S_COUNT-1:0]         m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
`ifdef AXIS_ARB_STATS_EN
  input  logic                          stat_clear,
  output logic [S_COUNT*STAT_WIDTH-1:0] stat_pkt_count,
`endif
  output logic                          grant_valid,
  output logic [CL_S_COUNT-1:0]         grant_index
);

  localparam int BEAT_W = CL_S_COUNT + 1 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

  state_t                r_state;
  logic                  r_grant_valid;
  logic [CL_S_COUNT-1:0] r_grant_index;
  logic [CL_S_COUNT-1:0] r_rr_ptr;
  logic                  w_win_valid;
  logic [CL_S_COUNT-1:0] w_win_index;
  logic [CL_S_COUNT-1:0] w_ptr_next;

  logic [DATA_WIDTH-1:0] w_s_data [S_COUNT];
  logic [KEEP_WIDTH-1:0] w_s_keep [S_COUNT];
  logic [USER_WIDTH-1:0] w_s_user [S_COUNT];
  logic                  w_sel_last;
  logic                  w_accept;
  logic [BEAT_W-1:0]     w_sel_beat;

  logic                  r_m_valid;
  logic [BEAT_W-1:0]     r_m_beat;
  logic                  r_out_full;
  logic [BEAT_W-1:0]     r_t_beat;
  logic [KEEP_WIDTH-1:0] w_out_keep;
  logic [USER_WIDTH-1:0] w_out_user;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_port
      assign w_s_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_s_keep[gi] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign w_s_user[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
      assign s_axis_tready[gi] = r_grant_valid && !r_out_full &&
                                 (r_grant_index == CL_S_COUNT'(gi));
    end
  endgenerate

  axis_rr_arbiter_core #(
    .S_COUNT (S_COUNT)
  ) u_core (
    .request      (s_axis_tvalid),
    .rr_ptr       (r_rr_ptr),
    .winner_index (w_win_index),
    .winner_valid (w_win_valid)
  );

  assign w_sel_last = s_axis_tlast[r_grant_index];
  assign w_accept   = r_grant_valid && !r_out_full && s_axis_tvalid[r_grant_index];
  assign w_sel_beat = {r_grant_index, w_sel_last, w_s_user[r_grant_index],
                       w_s_keep[r_grant_index], w_s_data[r_grant_index]};
  assign w_ptr_next = (r_grant_index == CL_S_COUNT'(S_COUNT - 1)) ? '0
                                                                  : r_grant_index + CL_S_COUNT'(1);

  // Grant is held until the tlast beat is accepted, so packets never interleave.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
      r_rr_ptr      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state       <= ST_GRANT;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_win_index;
          end
        end
        ST_GRANT: begin
          if (w_accept && w_sel_last) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_ptr_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Skid: the temp entry only fills when the output is stalled as a beat lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid  <= 1'b0;
      r_m_beat   <= '0;
      r_out_full <= 1'b0;
      r_t_beat   <= '0;
    end else if (r_out_full) begin
      if (m_axis_tready) begin
        r_m_beat   <= r_t_beat;
        r_out_full <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_m_valid || m_axis_tready) begin
        r_m_valid <= 1'b1;
        r_m_beat  <= w_sel_beat;
      end else begin
        r_out_full <= 1'b1;
        r_t_beat   <= w_sel_beat;
      end
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign {m_axis_tid, m_axis_tlast, w_out_user, w_out_keep, m_axis_tdata} = r_m_beat;
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? w_out_keep : '1;
  assign m_axis_tuser  = (USER_ENABLE != 0) ? w_out_user : '0;
  assign m_axis_tvalid = r_m_valid;
  assign grant_valid   = r_grant_valid;
  assign grant_index   = r_grant_index;

`ifdef AXIS_ARB_STATS_EN
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_stat
      logic [STAT_WIDTH-1:0] r_count;
      always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
          r_count <= '0;
        end else if (w_accept && w_sel_last && (r_grant_index == CL_S_COUNT'(gi))) begin
          r_count <= r_count + STAT_WIDTH'(1);
        end
      end
      assign stat_pkt_count[gi*STAT_WIDTH +: STAT_WIDTH] = r_count;
    end
  endgenerate
`endif

endmodule
`default_nettype wire
